pulse_train_gen: RTL and testbench

Generates a programmable train of clean rectangular pulses on `pulse_out` for the edge-detector path and board-level strobes. A single-cycle `start` request launches `num_pulses` pulses, each `high_len` cycles high and separated by `low_len` cycles low. Every pulse produces a distinct rising edge for the downstream `edge_detector`. `busy`, `done` and `pulse_cnt` report progress to the controlling FSM.

---
 rtl/pulse_train_gen_if.sv | 26 ++
 rtl/pulse_train_gen.sv | 131 +++++++++++++
 tb/tb_pulse_train_gen.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pulse_train_gen_if.sv
// Control/status bundle between the controlling FSM and pulse_train_gen.
// The controller drives the train configuration and start/stop; the generator reports progress.
interface pulse_train_gen_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned NUM_W = 8
);
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [NUM_W-1:0] num_pulses;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic [NUM_W-1:0] pulse_cnt;

  modport master (
    output start, stop, high_len, low_len, num_pulses,
    input  pulse_out, busy, done, pulse_cnt
  );

  modport slave (
    input  start, stop, high_len, low_len, num_pulses,
    output pulse_out, busy, done, pulse_cnt
  );
endinterface

// File: rtl/pulse_train_gen.sv
// Programmable rectangular pulse-train generator: num_pulses pulses of high_len cycles,
// separated by max(low_len,1) low cycles, with busy/done/pulse_cnt progress reporting.
module pulse_train_gen #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned NUM_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  pulse_train_gen_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] phase, phase_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [NUM_W-1:0] cnt_q, cnt_d;
  logic             last_c;

  // Final pulse: completion takes priority over a coincident stop.
  assign last_c = !(cnt_q < num_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      phase   <= '0;
      high_q  <= '0;
      low_q   <= '0;
      num_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_d;
      phase   <= phase_d;
      high_q  <= high_d;
      low_q   <= low_d;
      num_q   <= num_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    phase_d = phase;
    high_d  = high_q;
    low_d   = low_q;
    num_d   = num_q;
    pulse_d = pulse_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    unique case (state)
      IDLE: begin
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        if (bus.start) begin
          if ((bus.high_len != '0) && (bus.num_pulses != '0)) begin
            high_d  = bus.high_len;
            // A zero low phase would merge adjacent pulses, so clamp it to one cycle.
            low_d   = (bus.low_len == '0) ? CNT_W'(1) : bus.low_len;
            num_d   = bus.num_pulses;
            phase_d = bus.high_len;
            cnt_d   = NUM_W'(1);
            pulse_d = 1'b1;
            busy_d  = 1'b1;
            state_d = HIGH;
          end else begin
            cnt_d  = '0;
            done_d = 1'b1;
          end
        end
      end

      HIGH: begin
        if ((phase == CNT_W'(1)) && last_c) begin
          state_d = IDLE;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (bus.stop) begin
          state_d = IDLE;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
        end else if (phase == CNT_W'(1)) begin
          state_d = LOW;
          phase_d = low_q;
          pulse_d = 1'b0;
        end else begin
          phase_d = phase - CNT_W'(1);
        end
      end

      LOW: begin
        if (bus.stop) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (phase == CNT_W'(1)) begin
          state_d = HIGH;
          phase_d = high_q;
          pulse_d = 1'b1;
          cnt_d   = cnt_q + NUM_W'(1);
        end else begin
          phase_d = phase - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.pulse_out = pulse_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pulse_cnt = cnt_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed self-checking bench for pulse_train_gen: train shapes, zero config,
// stop, mid-train input changes, back-to-back start and asynchronous reset.
module tb_pulse_train_gen;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pulse_train_gen_if #(.CNT_W(8), .NUM_W(8)) bus ();

  pulse_train_gen #(.CNT_W(8), .NUM_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int h, input int l, input int n);
    bus.high_len   = 8'(h);
    bus.low_len    = 8'(l);
    bus.num_pulses = 8'(n);
    bus.start      = 1'b1;
  endtask

  // Steps a fixed number of cycles recording pulse_out (MSB first) and progress stats; start is dropped after each edge.
  task automatic capture(input int cycles, output logic [63:0] pat, output int busy_n,
                         output int rises, output int dones, output int done_step);
    logic prev;
    pat = '0; busy_n = 0; rises = 0; dones = 0; done_step = 0;
    prev = bus.pulse_out;
    for (int i = 1; i <= cycles; i++) begin
      step();
      bus.start = 1'b0;
      pat = {pat[62:0], bus.pulse_out};
      if (bus.busy) busy_n++;
      if (bus.pulse_out && !prev) rises++;
      prev = bus.pulse_out;
      if (bus.done) begin
        dones++;
        if (done_step == 0) done_step = i;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0;
    bus.high_len = '0; bus.low_len = '0; bus.num_pulses = '0;
    #23;
    checks++; if (bus.pulse_out !== 1'b0) begin failures++; $display("FAIL reset_pulse: got %b expected 0", bus.pulse_out); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.pulse_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", bus.pulse_cnt); end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [63:0] pat; int b, r, d, ds;
    launch(3, 2, 3);
    capture(16, pat, b, r, d, ds);
    checks++; if (pat[15:0] !== 16'b1110011100111000) begin failures++; $display("FAIL basic_pattern: got %b expected 1110011100111000", pat[15:0]); end
    checks++; if (b !== 13) begin failures++; $display("FAIL basic_busy: got %0d expected 13", b); end
    checks++; if (r !== 3) begin failures++; $display("FAIL basic_rises: got %0d expected 3", r); end
    checks++; if (d !== 1) begin failures++; $display("FAIL basic_done_count: got %0d expected 1", d); end
    checks++; if (ds !== 14) begin failures++; $display("FAIL basic_done_step: got %0d expected 14", ds); end
    checks++; if (bus.pulse_cnt !== 8'd3) begin failures++; $display("FAIL basic_cnt: got %0d expected 3", bus.pulse_cnt); end
  endtask

  task automatic test_low_zero();
    logic [63:0] pat; int b, r, d, ds;
    launch(2, 0, 2);
    capture(8, pat, b, r, d, ds);
    checks++; if (pat[7:0] !== 8'b11011000) begin failures++; $display("FAIL lowzero_pattern: got %b expected 11011000", pat[7:0]); end
    checks++; if (b !== 5) begin failures++; $display("FAIL lowzero_busy: got %0d expected 5", b); end
    checks++; if (r !== 2) begin failures++; $display("FAIL lowzero_rises: got %0d expected 2", r); end
    checks++; if (ds !== 6) begin failures++; $display("FAIL lowzero_done_step: got %0d expected 6", ds); end
    checks++; if (bus.pulse_cnt !== 8'd2) begin failures++; $display("FAIL lowzero_cnt: got %0d expected 2", bus.pulse_cnt); end
  endtask

  task automatic test_zero_config();
    logic [63:0] pat; int b, r, d, ds;
    launch(5, 1, 0);
    capture(3, pat, b, r, d, ds);
    checks++; if (pat[2:0] !== 3'b000) begin failures++; $display("FAIL zeron_pattern: got %b expected 000", pat[2:0]); end
    checks++; if (b !== 0) begin failures++; $display("FAIL zeron_busy: got %0d expected 0", b); end
    checks++; if (d !== 1 || ds !== 1) begin failures++; $display("FAIL zeron_done: got count %0d step %0d expected count 1 step 1", d, ds); end
    checks++; if (bus.pulse_cnt !== 8'd0) begin failures++; $display("FAIL zeron_cnt: got %0d expected 0", bus.pulse_cnt); end
    launch(1, 1, 1);
    capture(3, pat, b, r, d, ds);
    launch(0, 1, 3);
    capture(3, pat, b, r, d, ds);
    checks++; if (pat[2:0] !== 3'b000 || b !== 0) begin failures++; $display("FAIL zeroh_idle: got pattern %b busy %0d expected 000 busy 0", pat[2:0], b); end
    checks++; if (d !== 1 || ds !== 1) begin failures++; $display("FAIL zeroh_done: got count %0d step %0d expected count 1 step 1", d, ds); end
    checks++; if (bus.pulse_cnt !== 8'd0) begin failures++; $display("FAIL zeroh_cnt: got %0d expected 0", bus.pulse_cnt); end
  endtask

  task automatic test_stop();
    logic [63:0] pat; int b, r, d, ds;
    launch(4, 4, 5);
    step();
    bus.start = 1'b0;
    for (int i = 2; i <= 10; i++) step();
    checks++; if (bus.pulse_out !== 1'b1 || bus.pulse_cnt !== 8'd2) begin failures++; $display("FAIL stop_pre: got pulse %b cnt %0d expected pulse 1 cnt 2", bus.pulse_out, bus.pulse_cnt); end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    checks++; if (bus.pulse_out !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL stop_abort: got pulse %b busy %b expected 0 0", bus.pulse_out, bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL stop_nodone: got %b expected 0", bus.done); end
    checks++; if (bus.pulse_cnt !== 8'd2) begin failures++; $display("FAIL stop_cnt: got %0d expected 2", bus.pulse_cnt); end
    capture(3, pat, b, r, d, ds);
    checks++; if (d !== 0 || b !== 0) begin failures++; $display("FAIL stop_quiet: got dones %0d busy %0d expected 0 0", d, b); end
    launch(1, 1, 2);
    capture(5, pat, b, r, d, ds);
    checks++; if (pat[4:0] !== 5'b10100 || ds !== 4) begin failures++; $display("FAIL stop_restart: got %b done_step %0d expected 10100 done_step 4", pat[4:0], ds); end
  endtask

  task automatic test_ignore_inputs();
    logic [17:0] pat; logic prev; int b, r, ds;
    pat = '0; b = 0; r = 0; ds = 0; prev = 1'b0;
    launch(2, 2, 4);
    for (int i = 1; i <= 18; i++) begin
      step();
      bus.start = 1'b0;
      if (i == 3) begin
        bus.start = 1'b1;
        bus.high_len = 8'd7;
        bus.num_pulses = 8'd1;
      end
      pat = {pat[16:0], bus.pulse_out};
      if (bus.busy) b++;
      if (bus.pulse_out && !prev) r++;
      prev = bus.pulse_out;
      if (bus.done && ds == 0) ds = i;
    end
    checks++; if (pat !== 18'b110011001100110000) begin failures++; $display("FAIL midtrain_pattern: got %b expected 110011001100110000", pat); end
    checks++; if (b !== 14 || r !== 4) begin failures++; $display("FAIL midtrain_busy_rises: got busy %0d rises %0d expected 14 4", b, r); end
    checks++; if (ds !== 15) begin failures++; $display("FAIL midtrain_done_step: got %0d expected 15", ds); end
  endtask

  task automatic test_back_to_back();
    launch(1, 1, 1);
    step();
    bus.start = 1'b0;
    step();
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_first_done: got done %b busy %b expected 1 0", bus.done, bus.busy); end
    launch(2, 1, 1);
    step();
    bus.start = 1'b0;
    checks++; if (bus.pulse_out !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.pulse_cnt !== 8'd1) begin
      failures++; $display("FAIL b2b_restart: got pulse %b busy %b done %b cnt %0d expected 1 1 0 1", bus.pulse_out, bus.busy, bus.done, bus.pulse_cnt);
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_async_reset();
    logic [63:0] pat; int b, r, d, ds;
    launch(5, 1, 2);
    step();
    bus.start = 1'b0;
    step();
    checks++; if (bus.pulse_out !== 1'b1) begin failures++; $display("FAIL areset_pre: got %b expected 1", bus.pulse_out); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.pulse_out !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pulse_cnt !== 8'd0) begin
      failures++; $display("FAIL areset_outputs: got pulse %b busy %b done %b cnt %0d expected 0 0 0 0", bus.pulse_out, bus.busy, bus.done, bus.pulse_cnt);
    end
    step();
    reset = 1'b1;
    capture(6, pat, b, r, d, ds);
    checks++; if (pat[5:0] !== 6'b000000 || b !== 0 || d !== 0) begin failures++; $display("FAIL areset_idle: got pattern %b busy %0d dones %0d expected 000000 0 0", pat[5:0], b, d); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_low_zero();
    test_zero_config();
    test_stop();
    test_ignore_inputs();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
